// File: rtl/anubis_pkg.sv
// Shared types and constants for the Anubis iterative round controller.
package anubis_pkg;

    localparam int unsigned BLOCK_W    = 128;
    localparam int unsigned ROUNDS_MIN = 12;
    localparam int unsigned ROUNDS_MAX = 18;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Round count must be in range and fit the key-index width.
    function automatic bit rounds_legal(input int unsigned rounds, input int unsigned idx_w);
        return (rounds >= ROUNDS_MIN) && (rounds <= ROUNDS_MAX) && ((64'd1 << idx_w) > rounds);
    endfunction

endpackage

// File: rtl/anubis_round_ctrl_if.sv
// Block handshake, key-schedule and round-datapath signals of the round controller.
// ANUBIS_ROUND_CTRL_DECRYPT_EN adds the decrypt select.
interface anubis_round_ctrl_if #(
    parameter int unsigned IDX_W = 5
);
    import anubis_pkg::*;

    logic             in_valid;
    logic             in_ready;
    block_t           in_block;
    logic [IDX_W-1:0] rk_idx;
    block_t           rk;
    block_t           dp_in;
    logic             dp_last;
    block_t           dp_out;
    logic             out_valid;
    logic             out_ready;
    block_t           out_block;
    logic             busy;
`ifdef ANUBIS_ROUND_CTRL_DECRYPT_EN
    logic             decrypt;
`endif

    // Controller side.
    modport slave (
`ifdef ANUBIS_ROUND_CTRL_DECRYPT_EN
        input  decrypt,
`endif
        input  in_valid, in_block, rk, dp_out, out_ready,
        output in_ready, rk_idx, dp_in, dp_last, out_valid, out_block, busy
    );

    // Environment side: block source/sink, key schedule and round datapath.
    modport master (
`ifdef ANUBIS_ROUND_CTRL_DECRYPT_EN
        output decrypt,
`endif
        output in_valid, in_block, rk, dp_out, out_ready,
        input  in_ready, rk_idx, dp_in, dp_last, out_valid, out_block, busy
    );

endinterface

// File: rtl/anubis_round_cnt.sv
// Loadable up/down round-key index counter with terminal-count and illegal-value flags.
module anubis_round_cnt #(
    parameter int unsigned ROUNDS = 12,
    parameter int unsigned IDX_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic             i_down,
    input  logic             i_step,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last,
    output logic             o_bad
);

    localparam logic [IDX_W-1:0] LP_MAX = IDX_W'(ROUNDS);
    localparam logic [IDX_W-1:0] LP_ONE = IDX_W'(1);

    logic [IDX_W-1:0] r_idx;
    logic             r_down;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= '0;
            r_down <= 1'b0;
        end else if (i_clr) begin
            r_idx  <= '0;
            r_down <= 1'b0;
        end else if (i_load) begin
            // Whitening already consumed key 0 (or ROUNDS), so round 1 starts one step in.
            r_idx  <= i_down ? (LP_MAX - LP_ONE) : LP_ONE;
            r_down <= i_down;
        end else if (i_step) begin
            r_idx  <= r_down ? (r_idx - LP_ONE) : (r_idx + LP_ONE);
        end
    end

    assign o_idx  = r_idx;
    assign o_last = r_down ? (r_idx == '0) : (r_idx == LP_MAX);
    assign o_bad  = (r_idx > LP_MAX);

endmodule

// File: rtl/anubis_round_ctrl.sv
// Iterative Anubis round sequencer: whitening, ROUNDS datapath passes, then result handshake.
// Optional macro ANUBIS_ROUND_CTRL_DECRYPT_EN enables reversed key order for decryption.
module anubis_round_ctrl
    import anubis_pkg::*;
#(
    parameter int unsigned ROUNDS = 12,
    parameter int unsigned IDX_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    anubis_round_ctrl_if.slave bus
);

    if (!rounds_legal(ROUNDS, IDX_W)) begin : g_param_err
        $error("anubis_round_ctrl: illegal ROUNDS/IDX_W combination");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    block_t           r_block;
    logic             w_dec;
    logic             w_accept;
    logic             w_cnt_step;
    logic             w_cnt_clr;
    logic             w_cnt_last;
    logic             w_cnt_bad;
    logic [IDX_W-1:0] w_cnt_idx;
    logic [IDX_W-1:0] w_white_idx;

`ifdef ANUBIS_ROUND_CTRL_DECRYPT_EN
    assign w_dec = bus.decrypt;
`else
    assign w_dec = 1'b0;
`endif

    assign w_white_idx = w_dec ? IDX_W'(ROUNDS) : '0;
    assign w_accept    = bus.in_valid && (r_state == IDLE);
    assign w_cnt_step  = (r_state == ROUND) && !w_cnt_last;
    // Any exit to IDLE (normal, illegal state or counter) resets the counter.
    assign w_cnt_clr   = (r_state != IDLE) && (w_state_nxt == IDLE);

    anubis_round_cnt #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) u_round_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_load (w_accept),
        .i_down (w_dec),
        .i_step (w_cnt_step),
        .o_idx  (w_cnt_idx),
        .o_last (w_cnt_last),
        .o_bad  (w_cnt_bad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE:  w_state_nxt = bus.in_valid ? ROUND : IDLE;
            ROUND: begin
                if (w_cnt_bad) begin
                    w_state_nxt = IDLE;
                end else if (w_cnt_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = ROUND;
                end
            end
            DONE:  w_state_nxt = bus.out_ready ? IDLE : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.out_valid = (r_state == DONE);
        bus.busy      = (r_state != IDLE);
        bus.dp_last   = (r_state == ROUND) && w_cnt_last;
        bus.rk_idx    = (r_state == IDLE) ? w_white_idx : w_cnt_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_block <= '0;
        end else if (w_accept) begin
            r_block <= bus.in_block ^ bus.rk;
        end else if (r_state == ROUND) begin
            r_block <= bus.dp_out;
        end
    end

    assign bus.dp_in     = r_block;
    assign bus.out_block = r_block;

endmodule
